// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter; a push into an idle block puts the start bit on tx two edges later.
// Backpressure: data_ready drops while the FIFO is full, and words offered then are dropped.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_BITS-1:0]        data_in,
  input  logic                        data_valid,
  output logic                        data_ready,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [IW-1:0]        bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_bit_n;
  logic                 tx_n, tx_busy_n;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;
  logic                 push, pop, bit_end, fifo_nempty;

  assign data_ready  = (fifo_count != CW'(FIFO_DEPTH));
  assign push        = data_valid && data_ready;
  assign fifo_nempty = (fifo_count != '0);
  assign head        = mem[rd_ptr];
  assign head_par    = (PARITY_MODE == 2) ? ~^head : ^head;
  assign bit_end     = (bit_cnt == BW'(CLKS_PER_BIT - 1));

  // Storage carries no reset; emptiness is defined by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_end ? '0 : bit_cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    tx_n      = tx;
    tx_busy_n = tx_busy;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        bit_cnt_n = '0;
        pop       = fifo_nempty;
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = '0;
          tx_n      = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == IW'(DATA_BITS - 1)) begin
            if (PARITY_MODE != 0) begin
              state_n = PARITY;
              tx_n    = par_bit;
            end else begin
              state_n   = STOP;
              bit_idx_n = '0;
              tx_n      = 1'b1;
            end
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            shreg_n   = shreg >> 1;
            tx_n      = shreg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n   = STOP;
          bit_idx_n = '0;
          tx_n      = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_idx == IW'(STOP_BITS - 1)) begin
            if (fifo_nempty) begin
              pop = 1'b1;
            end else begin
              state_n   = IDLE;
              tx_n      = 1'b1;
              tx_busy_n = 1'b0;
            end
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Leaving IDLE or chaining from the last stop bit both start a fresh frame from the head word.
    if (pop) begin
      state_n   = START;
      bit_cnt_n = '0;
      shreg_n   = head;
      par_bit_n = head_par;
      tx_n      = 1'b0;
      tx_busy_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      par_bit <= par_bit_n;
      tx      <= tx_n;
      tx_busy <= tx_busy_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations, frames decoded off tx and matched against a queue
// of hand-computed frame vectors (bit 0 = first bit on the line).
module tb_uart_tx_fifo;
  typedef struct {
    int          ch;
    logic [15:0] bits;
  } exp_t;

  localparam int CPBV  [3] = '{4, 5, 4};
  localparam int FBITS [3] = '{11, 11, 10};

  logic clk = 1'b0;
  logic reset;
  logic [7:0] dat0, dat2;
  logic [6:0] dat1;
  logic dv0, dv1, dv2, rdy0, rdy1, rdy2, tx0, tx1, tx2, busy0, busy1, busy2;
  logic [2:0] cnt0, cnt1, cnt2;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  uart_tx_fifo u_dut0 (.clk(clk), .reset(reset), .data_in(dat0), .data_valid(dv0),
    .data_ready(rdy0), .tx(tx0), .tx_busy(busy0), .fifo_count(cnt0));
  uart_tx_fifo #(.CLKS_PER_BIT(5), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .reset(reset), .data_in(dat1), .data_valid(dv1),
    .data_ready(rdy1), .tx(tx1), .tx_busy(busy1), .fifo_count(cnt1));
  uart_tx_fifo #(.PARITY_MODE(0)) u_dut2 (.clk(clk), .reset(reset), .data_in(dat2), .data_valid(dv2),
    .data_ready(rdy2), .tx(tx2), .tx_busy(busy2), .fifo_count(cnt2));

  logic [2:0] txv, busyv, nzv;
  assign txv   = {tx2, tx1, tx0};
  assign busyv = {busy2, busy1, busy0};
  assign nzv   = {|cnt2, |cnt1, |cnt0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int ch, input int limit);
    int n;
    n = 0;
    while ((busyv[ch] || nzv[ch]) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(n < limit), 1);
    cyc(2);
  endtask

  // Reset as seen by the DUT at the last rising edge, so the monitor never races the stimulus.
  logic rst_q = 1'b1;
  always @(posedge clk) rst_q <= reset;

  int run [3] = '{0, 0, 0};
  int last_run [3] = '{0, 0, 0};
  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (busyv[c]) run[c]++;
      else if (run[c] != 0) begin
        last_run[c] = run[c];
        run[c] = 0;
      end
    end
  end

  int          pos [3] = '{-1, -1, -1};
  logic [15:0] cap [3];
  logic [2:0]  unstable, idle_in_frame;
  logic [2:0]  prev_tx = 3'b111;
  int          bi;
  exp_t        e;

  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (rst_q) begin
        pos[c] = -1;
      end else if (pos[c] < 0 && !txv[c] && prev_tx[c]) begin
        pos[c] = 0;
        cap[c] = '0;
        unstable[c] = 1'b0;
        idle_in_frame[c] = 1'b0;
      end
      if (pos[c] >= 0) begin
        bi = pos[c] / CPBV[c];
        if (pos[c] % CPBV[c] == 0) cap[c][bi] = txv[c];
        else if (txv[c] !== cap[c][bi]) unstable[c] = 1'b1;
        if (!busyv[c]) idle_in_frame[c] = 1'b1;
        if (pos[c] == FBITS[c] * CPBV[c] - 1) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame ch=%0d actual=%0h expected=none", c, cap[c]);
          end else begin
            e = exp_q.pop_front();
            chk("frame_channel", c, e.ch);
            chk("frame_bits", 32'(cap[c]), 32'(e.bits));
            chk("bit_hold", 32'(unstable[c]), 0);
            chk("busy_in_frame", 32'(idle_in_frame[c]), 0);
          end
          pos[c] = -1;
        end else begin
          pos[c]++;
        end
      end
      prev_tx[c] = txv[c];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  localparam logic [7:0]  W3 [3] = '{8'h01, 8'h02, 8'h03};
  localparam logic [15:0] F3 [3] = '{16'h0602, 16'h0604, 16'h0406};
  localparam int          C3 [3] = '{1, 1, 2};
  localparam int          CF [8] = '{0, 1, 1, 2, 3, 4, 4, 4};
  localparam logic        RF [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] FF [5] = '{16'h0400, 16'h0602, 16'h0604, 16'h0406, 16'h0608};

  initial begin
    int low;
    reset = 1'b1;
    dv0 = 1'b0; dv1 = 1'b0; dv2 = 1'b0;
    dat0 = '0; dat1 = '0; dat2 = '0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("rst_tx0", tx0, 1);
    chk("rst_busy0", busy0, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_rdy0", rdy0, 1);
    chk("rst_tx1", tx1, 1);
    chk("rst_tx2", tx2, 1);

    // Single 0xA5, even parity: 0,10100101,0,1
    @(negedge clk);
    dat0 = 8'hA5; dv0 = 1'b1;
    exp_q.push_back(exp_t'{0, 16'h054A});
    @(negedge clk);
    dv0 = 1'b0;
    chk("push_cnt", cnt0, 1);
    chk("push_busy", busy0, 0);
    chk("push_tx", tx0, 1);
    @(negedge clk);
    chk("start_tx", tx0, 0);
    chk("start_busy", busy0, 1);
    chk("start_cnt", cnt0, 0);
    wait_idle(0, 200);
    chk("busy_len_single", last_run[0], 44);
    chk("idle_tx", tx0, 1);

    // Three back-to-back words
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) chk("cnt_burst", cnt0, C3[i-1]);
      dat0 = W3[i]; dv0 = 1'b1;
      exp_q.push_back(exp_t'{0, F3[i]});
    end
    @(negedge clk);
    dv0 = 1'b0;
    chk("cnt_burst", cnt0, C3[2]);
    cyc(42); chk("cnt_pre_b1", cnt0, 2);
    cyc(1);  chk("cnt_post_b1", cnt0, 1);
    cyc(43); chk("cnt_pre_b2", cnt0, 1);
    cyc(1);  chk("cnt_post_b2", cnt0, 0);
    wait_idle(0, 300);
    chk("busy_len_burst", last_run[0], 132);

    // Hold valid for 8 cycles: words 0..4 accepted, 5..7 dropped
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("cnt_fill", cnt0, CF[i]);
      chk("ready_fill", rdy0, RF[i]);
      dat0 = 8'(i); dv0 = 1'b1;
      if (i < 5) exp_q.push_back(exp_t'{0, FF[i]});
    end
    @(negedge clk);
    dv0 = 1'b0;
    chk("cnt_full", cnt0, 4);
    chk("ready_full", rdy0, 0);
    wait_idle(0, 400);
    chk("busy_len_fill", last_run[0], 220);

    // Reset in the middle of the first frame's data bits
    @(negedge clk);
    dat0 = 8'h3C; dv0 = 1'b1;
    @(negedge clk);
    dat0 = 8'hC3;
    @(negedge clk);
    dv0 = 1'b0;
    cyc(15);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_tx", tx0, 1);
    chk("midrst_busy", busy0, 0);
    chk("midrst_cnt", cnt0, 0);
    chk("midrst_rdy", rdy0, 1);
    low = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!tx0 || busy0) low++;
    end
    chk("quiet_after_reset", low, 0);

    // Odd parity, 7 data bits, 2 stop bits, 5 clocks per bit: 0,1010101,1,1,1
    @(negedge clk);
    dat1 = 7'h55; dv1 = 1'b1;
    exp_q.push_back(exp_t'{1, 16'h07AA});
    @(negedge clk);
    dv1 = 1'b0;
    wait_idle(1, 200);
    chk("busy_len_odd", last_run[1], 55);
    chk("idle_tx1", tx1, 1);

    // No parity: 0,11111111,1
    @(negedge clk);
    dat2 = 8'hFF; dv2 = 1'b1;
    exp_q.push_back(exp_t'{2, 16'h03FE});
    @(negedge clk);
    dv2 = 1'b0;
    wait_idle(2, 200);
    chk("busy_len_nopar", last_run[2], 40);
    chk("idle_tx2", tx2, 1);

    cyc(5);
    chk("frames_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
